// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM (read latency 1) between the core's
// instruction-fetch port and its load/store port.
//
// Each requester has a combinational same-cycle grant and a tagged read
// response one cycle after the grant. The data port wins contention, but a
// saturating wait counter forces a pending fetch through after MAX_WAIT
// consecutive losses, so fetch cannot starve.
//
// Parameters:
//   MAX_WAIT    consecutive lost arbitrations before a fetch is forced (1..255)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_ireq/i_iaddr    fetch request and word address (read-only port)
//   o_igrant          fetch accepted this cycle
//   o_irvalid/o_irdata  fetch response (cycle after grant)
//   i_dreq/i_dwe      data request, 1 = store / 0 = load
//   i_daddr/i_dwdata/i_dmask  data word address, store data, byte enables
//   o_dgrant          data request accepted this cycle
//   o_drvalid/o_drdata  load response (cycle after grant)
//   o_mem_*           RAM command: enable, write enable, address, data, mask
//   i_mem_rdata       RAM read data, valid one cycle after a read access
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    // Instruction fetch port
    input  logic        i_ireq,
    input  logic [29:0] i_iaddr,
    output logic        o_igrant,
    output logic        o_irvalid,
    output logic [31:0] o_irdata,

    // Load/store port
    input  logic        i_dreq,
    input  logic        i_dwe,
    input  logic [29:0] i_daddr,
    input  logic [31:0] i_dwdata,
    input  logic [3:0]  i_dmask,
    output logic        o_dgrant,
    output logic        o_drvalid,
    output logic [31:0] o_drdata,

    // RAM macro side
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned   CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

    // Owner of the read response that the RAM returns this cycle
    typedef enum logic [1:0] {
        OwnNone,
        OwnInstr,
        OwnData
    } owner_e;

    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_d;
    owner_e        r_owner;
    owner_e        w_owner_d;

    logic          w_force;
    logic          w_igrant;
    logic          w_dgrant;

    // ------------------------------------------------------------------
    // Arbitration: data first, unless the fetch has waited MAX_WAIT cycles.
    // Grants are gated by rst so nothing reaches the RAM during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_force  = (r_wait_cnt == WAIT_SAT);
        w_igrant = 1'b0;
        w_dgrant = 1'b0;
        if (!rst) begin
            if (i_ireq && (!i_dreq || w_force)) begin
                w_igrant = 1'b1;
            end else if (i_dreq) begin
                w_dgrant = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait counter: counts consecutive losses of a pending fetch,
    // saturating at MAX_WAIT; any fetch grant or dropped request clears it.
    // ------------------------------------------------------------------
    always_comb begin
        w_wait_cnt_d = '0;
        if (i_ireq && !w_igrant) begin
            if (r_wait_cnt == WAIT_SAT) begin
                w_wait_cnt_d = r_wait_cnt;
            end else begin
                w_wait_cnt_d = r_wait_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tag: stores produce no response, so only reads set an owner.
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_d = OwnNone;
        if (w_igrant) begin
            w_owner_d = OwnInstr;
        end else if (w_dgrant && !i_dwe) begin
            w_owner_d = OwnData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_owner    <= OwnNone;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
            r_owner    <= w_owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_igrant    = w_igrant;
    assign o_dgrant    = w_dgrant;

    assign o_mem_en    = w_igrant | w_dgrant;
    assign o_mem_we    = w_dgrant & i_dwe;
    assign o_mem_addr  = w_igrant ? i_iaddr : i_daddr;
    assign o_mem_wdata = i_dwdata;
    // Fetches never write, so their mask is forced to zero
    assign o_mem_mask  = w_dgrant ? i_dmask : 4'b0000;

    assign o_irvalid   = (r_owner == OwnInstr);
    assign o_drvalid   = (r_owner == OwnData);
    assign o_irdata    = i_mem_rdata;
    assign o_drdata    = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A behavioural RAM answers the DUT's
// memory command; an independent transaction-level model predicts grants,
// responses and read data every cycle, and directed literal checks pin the
// model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        ireq;
    logic [29:0] iaddr;
    logic        igrant;
    logic        irvalid;
    logic [31:0] irdata;
    logic        dreq;
    logic        dwe;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dmask;
    logic        dgrant;
    logic        drvalid;
    logic [31:0] drdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_ireq      (ireq),
        .i_iaddr     (iaddr),
        .o_igrant    (igrant),
        .o_irvalid   (irvalid),
        .o_irdata    (irdata),
        .i_dreq      (dreq),
        .i_dwe       (dwe),
        .i_daddr     (daddr),
        .i_dwdata    (dwdata),
        .i_dmask     (dmask),
        .o_dgrant    (dgrant),
        .o_drvalid   (drvalid),
        .o_drdata    (drdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_mask  (mem_mask),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 'h10) return 32'h0050_0093;
        return {8'hA5, b, 8'h5A, ~b};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural RAM, driven by the DUT's memory command
    // ------------------------------------------------------------------
    logic [31:0] ram [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: who wins, what comes back next cycle, memory image
    // ------------------------------------------------------------------
    logic [31:0] m_mem [0:255];
    int          m_wait;   // consecutive cycles the current fetch has lost
    int          m_port;   // 0 nothing, 1 fetch, 2 load response due now
    logic [31:0] m_data;
    int          n_wait;
    int          n_port;
    logic [31:0] n_data;
    bit          n_st;
    logic [7:0]  n_st_addr;
    logic [31:0] n_st_word;
    bit          e_ig;
    bit          e_dg;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = init_word(i);
            m_mem[i] = init_word(i);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0;
            m_port <= 0;
            m_data <= '0;
        end else begin
            m_wait <= n_wait;
            m_port <= n_port;
            m_data <= n_data;
            if (n_st) m_mem[n_st_addr] <= n_st_word;
        end
    end

    // Compare process: outputs are combinational, so check mid-cycle
    always @(negedge clk) begin
        n_st      = 1'b0;
        n_st_addr = '0;
        n_st_word = '0;
        n_data    = '0;
        if (rst) begin
            chk("rst_igrant", 32'(igrant), 0);
            chk("rst_dgrant", 32'(dgrant), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_irvalid", 32'(irvalid), 0);
            chk("rst_drvalid", 32'(drvalid), 0);
            n_wait = 0;
            n_port = 0;
        end else begin
            e_ig = ireq && (!dreq || m_wait >= int'(MAX_WAIT));
            e_dg = dreq && !e_ig;
            chk("igrant", 32'(igrant), 32'(e_ig));
            chk("dgrant", 32'(dgrant), 32'(e_dg));
            chk("mem_en", 32'(mem_en), 32'(e_ig || e_dg));
            chk("mem_we", 32'(mem_we), 32'(e_dg && dwe));
            if (e_ig) begin
                chk("mem_addr_i", 32'(mem_addr), 32'(iaddr));
                chk("mem_mask_i", 32'(mem_mask), 0);
            end
            if (e_dg) begin
                chk("mem_addr_d", 32'(mem_addr), 32'(daddr));
                chk("mem_mask_d", 32'(mem_mask), 32'(dmask));
                if (dwe) chk("mem_wdata", mem_wdata, dwdata);
            end
            chk("irvalid", 32'(irvalid), 32'(m_port == 1));
            chk("drvalid", 32'(drvalid), 32'(m_port == 2));
            if (m_port == 1) chk("irdata", irdata, m_data);
            if (m_port == 2) chk("drdata", drdata, m_data);

            if (ireq && !e_ig) n_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
            else               n_wait = 0;
            if (e_ig) begin
                n_port = 1;
                n_data = m_mem[iaddr[7:0]];
            end else if (e_dg && !dwe) begin
                n_port = 2;
                n_data = m_mem[daddr[7:0]];
            end else begin
                n_port = 0;
            end
            if (e_dg && dwe) begin
                n_st      = 1'b1;
                n_st_addr = daddr[7:0];
                n_st_word = m_mem[daddr[7:0]];
                for (int b = 0; b < 4; b++) begin
                    if (dmask[b]) n_st_word[8*b +: 8] = dwdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] pattern;
    int         found;

    initial begin
        rst    = 1'b1;
        ireq   = 1'b0;
        iaddr  = '0;
        dreq   = 1'b0;
        dwe    = 1'b0;
        daddr  = '0;
        dwdata = '0;
        dmask  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted while a fetch read is in flight
        ireq  = 1'b1;
        iaddr = 30'h10;
        @(negedge clk);
        chk("t1_igrant", 32'(igrant), 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 ireq = 1'b0;
        @(negedge clk);
        chk("t1_no_irvalid", 32'(irvalid), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_mem_en_idle", 32'(mem_en), 0);
        chk("t1_no_irvalid_after", 32'(irvalid), 0);

        // Fetch alone
        step();
        ireq  = 1'b1;
        iaddr = 30'h10;
        @(negedge clk);
        chk("t2_igrant", 32'(igrant), 1);
        chk("t2_mem_addr", 32'(mem_addr), 32'h10);
        step();
        ireq = 1'b0;
        @(negedge clk);
        chk("t2_irvalid", 32'(irvalid), 1);
        chk("t2_irdata", irdata, 32'h0050_0093);
        chk("t2_drvalid", 32'(drvalid), 0);

        // Store then load
        step();
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 30'd5;
        dwdata = 32'hDEAD_BEEF;
        dmask  = 4'b0011;
        @(negedge clk);
        chk("t3_dgrant", 32'(dgrant), 1);
        chk("t3_mem_we", 32'(mem_we), 1);
        chk("t3_mem_mask", 32'(mem_mask), 32'h3);
        step();
        dreq = 1'b0;
        dwe  = 1'b0;
        @(negedge clk);
        chk("t3_no_drvalid", 32'(drvalid), 0);
        chk("t3_no_irvalid", 32'(irvalid), 0);
        step();
        dreq  = 1'b1;
        daddr = 30'd5;
        @(negedge clk);
        chk("t3_load_grant", 32'(dgrant), 1);
        chk("t3_load_we", 32'(mem_we), 0);
        step();
        dreq = 1'b0;
        @(negedge clk);
        chk("t3_drvalid", 32'(drvalid), 1);
        chk("t3_drdata", drdata, 32'hA505_BEEF);

        // Starvation bound: four data grants then one fetch, period 5
        step();
        ireq  = 1'b1;
        iaddr = 30'h20;
        dreq  = 1'b1;
        daddr = 30'h30;
        pattern = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pattern[i] = igrant;
            step();
        end
        chk("t4_pattern", 32'(pattern), 32'b10_0001_0000);

        // Back-to-back alternation
        ireq = 1'b0;
        dreq = 1'b0;
        step();
        ireq  = 1'b1;
        iaddr = 30'h10;
        @(negedge clk);
        chk("t5_c0_igrant", 32'(igrant), 1);
        step();
        ireq  = 1'b0;
        dreq  = 1'b1;
        daddr = 30'd5;
        @(negedge clk);
        chk("t5_c1_irvalid", 32'(irvalid), 1);
        chk("t5_c1_drvalid", 32'(drvalid), 0);
        chk("t5_c1_dgrant", 32'(dgrant), 1);
        step();
        dreq  = 1'b0;
        ireq  = 1'b1;
        iaddr = 30'h11;
        @(negedge clk);
        chk("t5_c2_drvalid", 32'(drvalid), 1);
        chk("t5_c2_irvalid", 32'(irvalid), 0);
        chk("t5_c2_igrant", 32'(igrant), 1);
        step();
        ireq = 1'b0;
        @(negedge clk);
        chk("t5_c3_irvalid", 32'(irvalid), 1);
        chk("t5_c3_irdata", irdata, 32'hA511_5AEE);
        chk("t5_c3_drvalid", 32'(drvalid), 0);

        // Counter clears when the fetch request drops
        step();
        step();
        ireq  = 1'b1;
        iaddr = 30'h20;
        dreq  = 1'b1;
        daddr = 30'h30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_pre_lose", 32'(igrant), 0);
            step();
        end
        ireq = 1'b0;
        @(negedge clk);
        chk("t6_drop_dgrant", 32'(dgrant), 1);
        step();
        ireq  = 1'b1;
        found = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (igrant === 1'b1) begin
                found = i;
                break;
            end
            step();
        end
        chk("t6_wait_cycles", 32'(found), 32'd4);

        step();
        ireq = 1'b0;
        dreq = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous RAM (read latency 1) between the core's instruction-fetch port and its load/store port. This allows instruction and data memory to live in one physical array. Each requester gets a single-cycle grant handshake and a tagged read response. The data port has priority, and a bounded-wait counter guarantees that instruction fetch cannot starve. The block sits between the core and the RAM macro.

## Interface
- `MAX_WAIT`, default 4: consecutive cycles a pending fetch may lose arbitration before it is forced through. Legal range is 1..255.
- `CW`, default `$clog2(MAX_WAIT+1)`: width of the wait counter. This is a local parameter.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_ireq` in 1: fetch request. Fetch is read-only.
- `i_iaddr` in 30: word address of the fetch.
- `o_igrant` out 1: fetch accepted this cycle.
- `o_irvalid` out 1: fetch data valid.
- `o_irdata` out 32: fetch data.
- `i_dreq` in 1: data request.
- `i_dwe` in 1: 1 means store, 0 means load.
- `i_daddr` in 30: word address of the data access.
- `i_dwdata` in 32: store data.
- `i_dmask` in 4: byte enables for the store.
- `o_dgrant` out 1: data request accepted.
- `o_drvalid` out 1: load data valid.
- `o_drdata` out 32: load data.
- `o_mem_en` out 1: RAM access enable.
- `o_mem_we` out 1: RAM write enable.
- `o_mem_addr` out 30: RAM word address.
- `o_mem_wdata` out 32: RAM write data.
- `o_mem_mask` out 4: RAM byte enables.
- `i_mem_rdata` in 32: RAM read data, valid one cycle after a read access.

## Operation
- **Handshake.** A requester holds `req` and its payload stable until it sees `grant`.
  - `grant` is combinational and occurs in the same cycle as the request.
  - A transfer occurs in any cycle where `req && grant`.
  - At most one grant is issued per cycle.
- **Arbitration.**
  - Only one port requesting: that port is granted.
  - Both ports requesting: the data port is granted, unless `wait_cnt == MAX_WAIT`, in which case the fetch port is granted.
- **Wait counter** (`wait_cnt`, CW bits, saturating):
  - Increments when `i_ireq && !o_igrant`.
  - Clears to 0 when the fetch port is granted or when `i_ireq` is low.
  - Saturates at MAX_WAIT and never wraps.
- **RAM drive.** RAM outputs carry the granted port's payload.
  - `o_mem_en = o_igrant | o_dgrant`.
  - `o_mem_we = o_dgrant & i_dwe`.
  - For a fetch grant, `o_mem_we = 0` and `o_mem_mask = 4'b0000`.
  - With no grant, the address, data and mask outputs are don't-care, but `o_mem_en` and `o_mem_we` are 0.
- **Response routing.**
  - The registered tag `resp_owner` takes one of three values: NONE, INSTR or DATA.
  - It is set to INSTR on a fetch grant and to DATA on a load grant.
  - It is set to NONE on a store grant or when there is no grant.
  - `o_irvalid = (resp_owner == INSTR)` and `o_drvalid = (resp_owner == DATA)`.
  - Both rdata outputs pass `i_mem_rdata` through. They are meaningful only while their own rvalid is high.
- **Stores** produce no response.
- **Back-to-back transfers.** A new grant can be issued in the same cycle a response is being delivered, so full throughput is one access per cycle.

## Timing
- **Latency.** A read granted in cycle N returns data with rvalid in cycle N+1.
- **Worst-case fetch wait.** With `i_dreq` held high continuously, a pending fetch is granted within MAX_WAIT+1 cycles of raising `i_ireq`.
- **Reset (`rst` high, asynchronous):**
  - `wait_cnt = 0` and `resp_owner = NONE`.
  - `o_irvalid`, `o_drvalid`, `o_igrant`, `o_dgrant`, `o_mem_en` and `o_mem_we` are all 0. Grants and enables are gated by `rst`.
  - A read granted in the cycle that `rst` asserts produces no response.
- **After reset release,** the first rising edge with `rst` low is a normal arbitration cycle.
- **Forced-fetch cycle.** The data requester sees `o_dgrant = 0` and must hold its request. It is granted the next cycle if it is still requesting, because the counter has cleared.
- **Simultaneous deliver and issue.** A response from cycle N-1 and a grant in cycle N are independent. `resp_owner` is overwritten at the N edge.

## Test plan
1. **Reset.** Assert `rst` mid-read (read granted, `rst` high before the next edge). Required: no rvalid at any point. After release, `o_mem_en = 0` with no requests.
2. **Fetch alone.** Fetch only, `i_iaddr = 30'h10`, RAM word `0x00500093`. Required: `o_igrant = 1` in cycle N. `o_irvalid = 1` and `o_irdata = 0x00500093` in cycle N+1. `o_drvalid` stays 0.
3. **Store then load.** Data store `addr = 5`, `wdata = 0xDEADBEEF`, `mask = 4'b0011`. Required: `o_mem_we = 1` and `mask = 0011`, with no rvalid in the following cycle. Then load `addr = 5`. Required: `o_drvalid` rises one cycle later with `o_drdata` equal to the RAM output.
4. **Starvation bound.** Hold `i_dreq` and `i_ireq` high continuously with MAX_WAIT = 4. Required:
   - Data is granted for 4 cycles, then fetch is granted in the 5th cycle.
   - `wait_cnt` returns to 0.
   - The pattern repeats with period 5.
5. **Back-to-back alternation.** Fetch at cycle 0, load at cycle 1, fetch at cycle 2, all with no contention. Required: `o_irvalid` at cycles 1 and 3 and `o_drvalid` at cycle 2. No rvalid is asserted for the wrong port.
6. **Counter reset on drop.** Contend for 3 cycles, drop `i_ireq` for 1 cycle, then contend again. Required: `wait_cnt` clears to 0, so the fetch waits a full 4 more cycles.
